// File: rtl/topk_tracker_pkg.sv
// topk_pkg: shared width helpers and the per-slot insertion decision type.
package topk_pkg;

    typedef enum logic [1:0] {KEEP, TAKE_DIN, TAKE_UPPER} ins_e;

    function automatic int rank_width(input int k);
        return ($clog2(k) > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int occ_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_tracker_if.sv
// topk_tracker_if: sample stream in, rank-select read port and counters out.
interface topk_tracker_if
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int SEEN_WIDTH = 16
);
    localparam int RANK_W = rank_width(K);
    localparam int OCC_W  = occ_width(K);

    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  clear;
    logic [RANK_W-1:0]     rank_sel;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [OCC_W-1:0]      occ_cnt;
    logic [SEEN_WIDTH-1:0] seen_cnt;

    modport master (
        output din_valid, din, clear, rank_sel,
        input  dout, dout_valid, occ_cnt, seen_cnt
    );

    modport slave (
        input  din_valid, din, clear, rank_sel,
        output dout, dout_valid, occ_cnt, seen_cnt
    );

endinterface

// File: rtl/topk_tracker_slot.sv
// topk_slot: one rank of the sorted array; decides keep / take din / shift from upper rank.
module topk_slot
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  ins_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] upper_entry_i,
    input  logic                  upper_occ_i,
    input  logic                  upper_gt_i,
    output logic [DATA_WIDTH-1:0] entry_o,
    output logic                  occ_o,
    output logic                  gt_o
);
    logic [DATA_WIDTH-1:0] entry_q, entry_d;
    logic                  occ_q, occ_d;
    ins_e                  dec;

    // Clear makes every slot look empty, so only the head slot (upper_gt tied low) takes din.
    always_comb begin
        gt_o    = clear_i || !occ_q || (din_i > entry_q);
        dec     = (!ins_i || !gt_o) ? KEEP : (upper_gt_i ? TAKE_UPPER : TAKE_DIN);
        entry_d = (dec == TAKE_DIN) ? din_i :
                  clear_i ? '0 :
                  (dec == TAKE_UPPER) ? upper_entry_i : entry_q;
        occ_d   = clear_i ? (dec == TAKE_DIN) : (occ_q || (ins_i && upper_occ_i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
            occ_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            occ_q   <= occ_d;
        end
    end

    assign entry_o = entry_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/topk_tracker.sv
// topk_tracker: keeps the K largest unsigned samples sorted descending, any rank readable per cycle.
// Define TOPK_TRACKER_DISTINCT_EN to reject samples equal to an occupied entry.
module topk_tracker
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int SEEN_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    topk_tracker_if.slave bus
);
    localparam int RANK_W = rank_width(K);
    localparam int OCC_W  = occ_width(K);

    // Index 0 is a virtual always-occupied head above rank 0; rank r lives at index r+1.
    logic [K:0][DATA_WIDTH-1:0] ent;
    logic [K:0]                 occ;
    logic [K:0]                 gt;
    logic                       ins;
    logic                       unused_gt;
    logic [OCC_W-1:0]           occ_cnt;
    logic [SEEN_WIDTH-1:0]      seen_q, seen_d;

    assign ent[0]    = '0;
    assign occ[0]    = 1'b1;
    assign gt[0]     = 1'b0;
    assign unused_gt = gt[K];

`ifdef TOPK_TRACKER_DISTINCT_EN
    logic dup;
    always_comb begin
        dup = 1'b0;
        for (int j = 1; j <= K; j++) dup |= occ[j] && (ent[j] == bus.din);
    end
    assign ins = bus.din_valid && (bus.clear || !dup);
`else
    assign ins = bus.din_valid;
`endif

    for (genvar i = 0; i < K; i++) begin : g_slot
        topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk           (clk),
            .reset         (reset),
            .din_i         (bus.din),
            .ins_i         (ins),
            .clear_i       (bus.clear),
            .upper_entry_i (ent[i]),
            .upper_occ_i   (occ[i]),
            .upper_gt_i    (gt[i]),
            .entry_o       (ent[i+1]),
            .occ_o         (occ[i+1]),
            .gt_o          (gt[i+1])
        );
    end

    always_comb begin
        occ_cnt = '0;
        for (int j = 1; j <= K; j++) occ_cnt += OCC_W'(occ[j]);
    end

    assign seen_d = (bus.din_valid && !(&seen_q)) ? seen_q + 1'b1 : seen_q;

    always_ff @(posedge clk) begin
        if (reset) seen_q <= '0;
        else       seen_q <= seen_d;
    end

    always_comb begin
        bus.dout       = '0;
        bus.dout_valid = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (bus.rank_sel == RANK_W'(j)) begin
                bus.dout       = occ[j+1] ? ent[j+1] : '0;
                bus.dout_valid = occ[j+1];
            end
        end
    end

    assign bus.occ_cnt  = occ_cnt;
    assign bus.seen_cnt = seen_q;

endmodule

// File: tb/tb_topk_tracker.sv
// tb_topk_tracker: directed vectors for K=4, 8-bit samples, 3-bit seen counter.
module tb_topk_tracker;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef TOPK_TRACKER_DISTINCT_EN
    localparam bit DISTINCT = 1'b1;
`else
    localparam bit DISTINCT = 1'b0;
`endif

    topk_tracker_if #(.DATA_WIDTH(8), .K(4), .SEEN_WIDTH(3)) bus ();

    topk_tracker #(.DATA_WIDTH(8), .K(4), .SEEN_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        bus.din       = 8'(v);
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_ranks(input string tag, input int occ_e, input int seen_e,
                               input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        check({tag, ".occ"}, int'(bus.occ_cnt), occ_e);
        check({tag, ".seen"}, int'(bus.seen_cnt), seen_e);
        for (int r = 0; r < 4; r++) begin
            bus.rank_sel = 2'(r);
            #1;
            check($sformatf("%s.dout%0d", tag, r), int'(bus.dout), exp_v[r]);
            check($sformatf("%s.vld%0d", tag, r), int'(bus.dout_valid), (r < occ_e) ? 1 : 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.clear     = 1'b0;
        bus.rank_sel  = '0;
        tick();
        reset = 1'b0;
        check_ranks("rst", 0, 0, 0, 0, 0, 0);

        push(5); push(9); push(3);
        check_ranks("t593", 3, 3, 9, 5, 3, 0);

        do_reset();
        push(7);
        check_ranks("single7", 1, 1, 7, 0, 0, 0);

        do_reset();
        push(4); push(4); push(4); push(2); push(4);
        if (DISTINCT) check_ranks("dup4", 2, 5, 4, 2, 0, 0);
        else          check_ranks("dup4", 4, 5, 4, 4, 4, 4);

        do_reset();
        push(20); push(15); push(10); push(5);
        check_ranks("fill", 4, 4, 20, 15, 10, 5);
        push(3);
        check_ranks("drop3", 4, 5, 20, 15, 10, 5);
        push(12);
        check_ranks("evict", 4, 6, 20, 15, 12, 10);

        bus.clear = 1'b1;
        push(1);
        bus.clear = 1'b0;
        check_ranks("clrdin", 1, 7, 1, 0, 0, 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_ranks("clr", 0, 7, 0, 0, 0, 0);

        push(30);
        check_ranks("afterclr", 1, 7, 30, 0, 0, 0);
        reset         = 1'b1;
        bus.clear     = 1'b1;
        bus.din_valid = 1'b1;
        bus.din       = 8'd50;
        tick();
        reset         = 1'b0;
        bus.clear     = 1'b0;
        bus.din_valid = 1'b0;
        check_ranks("rstmid", 0, 0, 0, 0, 0, 0);

        for (int v = 1; v <= 9; v++) push(v);
        check_ranks("sat", 4, 7, 9, 8, 7, 6);

        do_reset();
        push(0);
        check_ranks("zero", 1, 1, 0, 0, 0, 0);
        push(3);
        check_ranks("zero3", 2, 2, 3, 0, 0, 0);
        bus.din_valid = 1'b0;
        bus.din       = 8'd200;
        tick();
        check_ranks("idle", 2, 2, 3, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
